// File: rtl/mux_func_sweeper_if.sv
// Bundle of signals between the sweeper and the 3-input MUX function stage
// it exercises, plus the start/done/result status seen by the requester.
//
// Handshake: `start` is a request level sampled only while the sweeper is
// idle; it is neither acknowledged nor queued while a sweep is running.
// `done` is a one-cycle completion pulse. `pass`, `err_count` and
// `fail_mask` are valid from the `done` cycle and stay stable until the
// next accepted `start`. `busy` is high exactly while vectors are driven.
interface mux_func_sweeper_if;
  logic       start;
  logic       sA;
  logic       sB;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;

  // Sweeper side: drives vectors and status, observes the stage outputs.
  modport master (
    input  start, sA, sB,
    output a, b, c, busy, done, pass, err_count, fail_mask
  );

  // Stage / requester side: the mirror view.
  modport slave (
    output start, sA, sB,
    input  a, b, c, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/mux_func_sweeper.sv
// Clocked self-checking sweep of the MUX logic-function stage.
// Drives all 8 (a,b,c) vectors, holds each for HOLD cycles, compares the
// stage outputs with expA = a^c and expB = a^b^c and reports results.
module mux_func_sweeper #(
  parameter int HOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_func_sweeper_if.master    bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] hold_cnt;

  logic       exp_a;
  logic       exp_b;
  logic       vec_fail;
  logic [3:0] err_next;
  logic [2:0] idx_next;

  assign dbg_state = state;

  // Compare the stage outputs against values derived from the registered vector.
  always_comb begin
    exp_a    = bus.a ^ bus.c;
    exp_b    = bus.a ^ bus.b ^ bus.c;
    vec_fail = (bus.sA != exp_a) || (bus.sB != exp_b);
    err_next = bus.err_count + {3'b000, vec_fail};
    idx_next = idx + 3'd1;
  end

  // Sweep controller: all outputs registered, reset has top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      hold_cnt      <= 4'd0;
      bus.a         <= 1'b0;
      bus.b         <= 1'b0;
      bus.c         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= 4'd0;
      bus.fail_mask <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.a    <= 1'b0;
          bus.b    <= 1'b0;
          bus.c    <= 1'b0;
          if (bus.start) begin
            state         <= RUN;
            idx           <= 3'd0;
            hold_cnt      <= 4'd0;
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.err_count <= 4'd0;
            bus.fail_mask <= 8'h00;
            // Vector 0 is all zeros; a,b,c already held low in IDLE.
          end
        end

        RUN: begin
          if (hold_cnt == HOLD_LAST) begin
            bus.err_count      <= err_next;
            bus.fail_mask[idx] <= vec_fail;
            if (idx == 3'd7) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (err_next == 4'd0);
              bus.a    <= 1'b0;
              bus.b    <= 1'b0;
              bus.c    <= 1'b0;
            end else begin
              idx      <= idx_next;
              hold_cnt <= 4'd0;
              // Index bit mapping: c = idx[2], a = idx[1], b = idx[0].
              bus.c    <= idx_next[2];
              bus.a    <= idx_next[1];
              bus.b    <= idx_next[0];
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_func_sweeper.sv
// Bench for mux_func_sweeper: two instances (HOLD = 1 and HOLD = 3), each
// driving a faultable function stage, checked every cycle against a
// time-since-start model of the sweep.
module tb_mux_func_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_v;
  logic [3:0]  fault_v;
  logic        chk_en;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  done_v;
  logic [1:0]  busy_v;
  logic [1:0]  pass_v;
  logic [7:0]  err_v;
  logic [15:0] mask_v;
  logic [3:0]  dbg_v;
  logic [3:0]  idle_code;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Function stage with selectable faults: returns {sA, sB}.
  // 0 golden, 1 sA stuck at 0, 2 sB inverted, 3 sB wrong only at a=b=c=1.
  function automatic logic [1:0] stage(input logic [1:0] f, input logic a, input logic b, input logic c);
    logic sa, sb;
    sa = a ^ c;
    sb = a ^ b ^ c;
    case (f)
      2'd1: sa = 1'b0;
      2'd2: sb = ~(a ^ b ^ c);
      2'd3: if (a & b & c) sb = ~sb;
      default: ;
    endcase
    return {sa, sb};
  endfunction

  // Which sweep indices must be reported failing under a given fault.
  function automatic logic [7:0] fail_bits(input logic [1:0] f);
    logic [7:0] fb;
    logic [2:0] v;
    logic [1:0] so;
    fb = 8'h00;
    for (int j = 0; j < 8; j++) begin
      v  = 3'(j);
      so = stage(f, v[1], v[0], v[2]);
      fb[j] = (so[1] != (v[1] ^ v[2])) || (so[0] != (v[1] ^ v[0] ^ v[2]));
    end
    return fb;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_i
    localparam int H = (g == 0) ? 1 : 3;

    mux_func_sweeper_if sw ();

    assign sw.start = start_v[g];
    assign {sw.sA, sw.sB} = stage(fault_v[g*2 +: 2], sw.a, sw.b, sw.c);

    mux_func_sweeper #(.HOLD(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (sw),
      .dbg_state (dbg_v[g*2 +: 2])
    );

    assign done_v[g]        = sw.done;
    assign busy_v[g]        = sw.busy;
    assign pass_v[g]        = sw.pass;
    assign err_v[g*4 +: 4]  = sw.err_count;
    assign mask_v[g*8 +: 8] = sw.fail_mask;

    // Model: m_t = cycles since the accepted start edge, -1 while idle.
    int         m_t = -1;
    logic [7:0] m_fails = 8'h00;
    logic [7:0] h_mask = 8'h00;
    logic       h_pass = 1'b0;

    always @(posedge clk) begin
      if (!rst_n) begin
        m_t = -1;
        h_mask = 8'h00;
        h_pass = 1'b0;
      end else if (m_t < 0) begin
        if (start_v[g]) begin
          m_t     = 0;
          m_fails = fail_bits(fault_v[g*2 +: 2]);
          h_mask  = 8'h00;
          h_pass  = 1'b0;
        end
      end else if (m_t == 8 * H) begin
        m_t    = -1;
        h_mask = m_fails;
        h_pass = (m_fails == 8'h00);
      end else begin
        m_t = m_t + 1;
      end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
      logic [2:0] e_v;
      logic [2:0] e_abc;
      logic       e_busy, e_done, e_pass;
      logic [7:0] e_mask;
      int         k;
      if (chk_en) begin
        if (m_t < 0) begin
          e_abc = 3'b000; e_busy = 1'b0; e_done = 1'b0;
          e_mask = h_mask; e_pass = h_pass;
        end else if (m_t < 8 * H) begin
          k      = m_t / H;
          e_v    = 3'(k);
          e_abc  = {e_v[1], e_v[0], e_v[2]};
          e_busy = 1'b1; e_done = 1'b0; e_pass = 1'b0;
          e_mask = m_fails & 8'((1 << k) - 1);
        end else begin
          e_abc = 3'b000; e_busy = 1'b0; e_done = 1'b1;
          e_mask = m_fails; e_pass = (m_fails == 8'h00);
        end
        check($sformatf("h%0d abc", H), 32'({sw.a, sw.b, sw.c}), 32'(e_abc));
        check($sformatf("h%0d busy", H), 32'(sw.busy), 32'(e_busy));
        check($sformatf("h%0d done", H), 32'(sw.done), 32'(e_done));
        check($sformatf("h%0d pass", H), 32'(sw.pass), 32'(e_pass));
        check($sformatf("h%0d err_count", H), 32'(sw.err_count), 32'($countones(e_mask)));
        check($sformatf("h%0d fail_mask", H), 32'(sw.fail_mask), 32'(e_mask));
        check($sformatf("h%0d state_idle", H), 32'(dbg_v[g*2 +: 2] == idle_code[g*2 +: 2]), 32'(m_t < 0));
      end
    end
  end

  // Driver: one start pulse, optional stray start and reset pulse at offsets
  // from T0, waits (bounded) for done and checks its latency.
  task automatic run_sweep(input int g, input int f, input int extra_at, input int rst_at, input int exp_lat);
    int t0, n;
    bit got;
    @(negedge clk);
    fault_v[g*2 +: 2] = 2'(f);
    start_v[g] = 1'b1;
    @(negedge clk);
    t0 = cyc;
    start_v[g] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      n = cyc - t0;
      if (done_v[g]) begin
        got = 1'b1;
        check("done latency", 32'(n), 32'(exp_lat));
        break;
      end
      if (rst_at >= 0 && n >= rst_at + 12) break;
      start_v[g] = (n == extra_at - 1);
      rst_n      = (n == rst_at - 1) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    start_v[g] = 1'b0;
    rst_n = 1'b1;
    check("done seen", 32'(got), (rst_at >= 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int g, f, ex;
    rst_n = 1'b0;
    start_v = 2'b00;
    fault_v = 4'h0;
    chk_en = 1'b0;
    idle_code = 4'h0;
    repeat (2) @(negedge clk);
    idle_code = dbg_v;
    chk_en = 1'b1;
    check("rst busy", 32'(busy_v), 32'd0);
    check("rst done", 32'(done_v), 32'd0);
    check("rst pass", 32'(pass_v), 32'd0);
    check("rst err", 32'(err_v), 32'd0);
    check("rst mask", 32'(mask_v), 32'd0);
    rst_n = 1'b1;

    run_sweep(0, 0, -1, -1, 8);
    check("golden pass", 32'(pass_v[0]), 32'd1);
    check("golden err", 32'(err_v[3:0]), 32'd0);
    check("golden mask", 32'(mask_v[7:0]), 32'h00);

    run_sweep(0, 1, -1, -1, 8);
    check("sA0 err", 32'(err_v[3:0]), 32'd4);
    check("sA0 mask", 32'(mask_v[7:0]), 32'h3C);
    check("sA0 pass", 32'(pass_v[0]), 32'd0);

    run_sweep(0, 2, -1, -1, 8);
    check("sBinv err", 32'(err_v[3:0]), 32'd8);
    check("sBinv mask", 32'(mask_v[7:0]), 32'hFF);
    check("sBinv pass", 32'(pass_v[0]), 32'd0);

    run_sweep(0, 0, -1, -1, 8);
    check("rerun err", 32'(err_v[3:0]), 32'd0);
    check("rerun pass", 32'(pass_v[0]), 32'd1);

    run_sweep(1, 0, 5, -1, 24);
    check("hold3 pass", 32'(pass_v[1]), 32'd1);
    repeat (30) @(negedge clk);
    check("hold3 no resweep", 32'(busy_v[1]), 32'd0);

    run_sweep(0, 0, -1, 4, 0);
    check("abort busy", 32'(busy_v[0]), 32'd0);
    check("abort err", 32'(err_v[3:0]), 32'd0);
    check("abort mask", 32'(mask_v[7:0]), 32'h00);
    check("abort pass", 32'(pass_v[0]), 32'd0);

    run_sweep(0, 0, -1, -1, 8);
    check("post-abort pass", 32'(pass_v[0]), 32'd1);

    run_sweep(0, 3, -1, -1, 8);
    check("v7 mask", 32'(mask_v[7:0]), 32'h80);
    check("v7 err", 32'(err_v[3:0]), 32'd1);
    check("v7 pass", 32'(pass_v[0]), 32'd0);
    repeat (5) @(negedge clk);
    check("v7 idle done", 32'(done_v[0]), 32'd0);
    check("v7 idle busy", 32'(busy_v[0]), 32'd0);

    for (int i = 0; i < 10; i++) begin
      g  = int'($urandom_range(0, 1));
      f  = int'($urandom_range(0, 3));
      ex = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (g == 0) ? 6 : 22)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(g, f, ex, -1, (g == 0) ? 8 : 24);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
